// File: rtl/modex_scan_controller.sv
// Frame-scan sequencer for the RSA pixel-decryption path: fetch a pixel pair, launch Mod_Exp, stream the result out.
// Optional build macro MODEX_TIMEOUT_EN adds a WAIT watchdog and a sticky error flag.
module modex_scan_controller #(
    parameter int ARQ       = 16,
    parameter int ADDR      = 18,
    parameter int NUM_PAIRS = 4096,
    parameter int BASE_ADDR = 0,
    parameter int EXP_KEY   = 1927,
    parameter int MOD_KEY   = 1349,
    parameter int TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR-1:0]   mem_addr,
    input  logic [ARQ-1:0]    mem_data_hi,
    input  logic [ARQ-1:0]    mem_data_lo,
    output logic [2*ARQ-1:0]  modex_operand,
    output logic [ARQ-1:0]    modex_exp,
    output logic [ARQ-1:0]    modex_mod,
    output logic              modex_start,
    input  logic              modex_done,
    input  logic [ARQ-1:0]    modex_result,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR-1:0]   wr_addr,
    output logic [ARQ-1:0]    wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | latch packed pixel pair into the operand register
    // LAUNCH | one-cycle start pulse to the core
    // WAIT   | waiting for core result
    // WRITE  | offer result downstream until wr_ready
    // FIN    | one-cycle frame done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_WRITE, S_FIN
    } state_t;

    state_t state, state_nxt;
    logic   last_pair;
    logic   wait_expired;

    assign modex_exp = ARQ'(EXP_KEY);
    assign modex_mod = ARQ'(MOD_KEY);
    assign last_pair = (wr_addr == ADDR'(NUM_PAIRS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        modex_start = 1'b0;
        wr_en       = 1'b0;
        done        = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE:   if (start && !abort) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_LAUNCH;
            S_LAUNCH: begin
                modex_start = 1'b1;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (modex_done)        state_nxt = S_WRITE;
                else if (wait_expired) state_nxt = S_IDLE;
            end
            S_WRITE: begin
                wr_en = 1'b1;
                if (wr_ready) state_nxt = last_pair ? S_FIN : S_FETCH;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
        // abort suppresses every outgoing strobe in the same cycle
        if (abort && state != S_IDLE) begin
            state_nxt   = S_IDLE;
            modex_start = 1'b0;
            wr_en       = 1'b0;
            done        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr      <= ADDR'(BASE_ADDR);
            wr_addr       <= '0;
            modex_operand <= '0;
            wr_data       <= '0;
        end else begin
            if (state == S_IDLE && state_nxt == S_FETCH) begin
                mem_addr <= ADDR'(BASE_ADDR);
                wr_addr  <= '0;
            end
            if (state == S_FETCH)
                modex_operand <= {{(2*ARQ-16){1'b0}}, mem_data_hi[7:0], mem_data_lo[7:0]};
            if (state == S_WAIT && state_nxt == S_WRITE)
                wr_data <= modex_result;
            if (state == S_WRITE && state_nxt == S_FETCH) begin
                mem_addr <= mem_addr + ADDR'(2);
                wr_addr  <= wr_addr + ADDR'(1);
            end
        end
    end

    // only the low byte of each pixel carries ciphertext
    logic unused_pixel_bits;
    assign unused_pixel_bits = ^{mem_data_hi[ARQ-1:8], mem_data_lo[ARQ-1:8]};

`ifdef MODEX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          error_q;

    assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));
    assign error        = error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            if (state == S_LAUNCH)    wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + TW'(1);
            if (state == S_WAIT && !modex_done && wait_expired && !abort)
                error_q <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign wait_expired = 1'b0;
    assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_modex_scan_controller.sv
// Self-checking bench for modex_scan_controller: directed + randomized frames against a pixel/core reference model.
module tb_modex_scan_controller;
    localparam int ARQ = 16;
    localparam int ADDR = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b, abort, wr_ready, modex_done;
    logic [15:0] modex_result;

    logic [17:0] mem_addr_a, wr_addr_a, mem_addr_b, wr_addr_b;
    logic [15:0] hi_a, lo_a, exp_a, mod_a, wr_data_a, hi_b, lo_b, exp_b, mod_b, wr_data_b;
    logic [31:0] op_a, op_b;
    logic mstart_a, wr_en_a, busy_a, done_a, err_a;
    logic mstart_b, wr_en_b, busy_b, done_b, err_b;

    int errors = 0;
    int checks = 0;

    // memory model: mode 0 = 0x11,0x22,...; mode 1 = random; mode 2 = random with upper byte 0xAB
    int unsigned seed = 0;
    int mem_mode = 0;

    function automatic logic [15:0] pix(input logic [17:0] a, input int unsigned s, input int mode);
        logic [31:0] h;
        h = (32'(a) * 32'h9E3779B1) ^ s;
        h = h ^ (h >> 15);
        if (mode == 0) return 16'(17 * (int'(a) + 1));
        if (mode == 2) return {8'hAB, h[7:0]};
        return h[15:0];
    endfunction

    assign hi_a = pix(mem_addr_a, seed, mem_mode);
    assign lo_a = pix(mem_addr_a + 18'd1, seed, mem_mode);
    assign hi_b = pix(mem_addr_b, seed, mem_mode);
    assign lo_b = pix(mem_addr_b + 18'd1, seed, mem_mode);

    modex_scan_controller #(.ARQ(16), .ADDR(18), .NUM_PAIRS(3), .BASE_ADDR(0), .TIMEOUT(10)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .mem_addr(mem_addr_a), .mem_data_hi(hi_a), .mem_data_lo(lo_a),
        .modex_operand(op_a), .modex_exp(exp_a), .modex_mod(mod_a),
        .modex_start(mstart_a), .modex_done(modex_done), .modex_result(modex_result),
        .wr_en(wr_en_a), .wr_ready(wr_ready), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .done(done_a), .error(err_a));

    modex_scan_controller #(.ARQ(16), .ADDR(18), .NUM_PAIRS(2), .BASE_ADDR(18'h3FFFE), .TIMEOUT(10)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .mem_addr(mem_addr_b), .mem_data_hi(hi_b), .mem_data_lo(lo_b),
        .modex_operand(op_b), .modex_exp(exp_b), .modex_mod(mod_b),
        .modex_start(mstart_b), .modex_done(modex_done), .modex_result(modex_result),
        .wr_en(wr_en_b), .wr_ready(wr_ready), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b), .error(err_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // core model: result = operand+1, done pulse lat+1 cycles after the launch edge
    int  lat_fixed = 5;
    bit  core_mute = 0;
    int  core_cnt = 0;
    bit  pending = 0;
    always @(posedge clk) begin
        modex_done <= 1'b0;
        if (mstart_a || mstart_b) begin
            pending      <= !core_mute;
            core_cnt     <= (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
            modex_result <= (mstart_a ? op_a[15:0] : op_b[15:0]) + 16'd1;
        end else if (pending) begin
            if (core_cnt <= 1) begin
                modex_done <= 1'b1;
                pending    <= 1'b0;
            end else core_cnt <= core_cnt - 1;
        end
    end

    // wr_ready driver: 0 always ready, 1 random, 2 seven-cycle stall on pair 1
    int rdy_mode = 0;
    int stall_cnt = 0;
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: wr_ready = 1'($urandom_range(0, 1));
                2: if (wr_en_a && wr_addr_a == 18'd1 && stall_cnt < 7) begin
                       wr_ready = 1'b0;
                       stall_cnt++;
                   end else wr_ready = 1'b1;
                default: wr_ready = 1'b1;
            endcase
        end
    end

    logic [31:0] op_q[$];
    logic [17:0] ma_q[$];
    logic [17:0] wa_q[$];
    logic [15:0] wd_q[$];
    int done_cnt = 0;
    int stall_seen = 0;

    always @(negedge clk) begin
        if (mstart_a) begin op_q.push_back(op_a); ma_q.push_back(mem_addr_a); end
        if (mstart_b) begin op_q.push_back(op_b); ma_q.push_back(mem_addr_b); end
        if (wr_en_a && wr_ready) begin wa_q.push_back(wr_addr_a); wd_q.push_back(wr_data_a); end
        if (wr_en_b && wr_ready) begin wa_q.push_back(wr_addr_b); wd_q.push_back(wr_data_b); end
        if (done_a || done_b) done_cnt++;
        if (rdy_mode == 2 && wr_en_a && !wr_ready) begin
            stall_seen++;
            chk("stall_wr_addr", 64'(wr_addr_a), 64'd1);
            chk("stall_wr_data", 64'(wr_data_a), 64'h3345);
            chk("stall_mem_addr", 64'(mem_addr_a), 64'd2);
        end
    end

    task automatic run_frame(input bit use_b, input int npairs, input logic [17:0] base,
                             input bit check_lat, input int lat);
        bit got;
        int bc;
        logic [17:0] a;
        logic [15:0] ph, pl;
        logic [31:0] eop;
        op_q.delete(); ma_q.delete(); wa_q.delete(); wd_q.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        got = 0; bc = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("first_mem_addr", 64'(use_b ? mem_addr_b : mem_addr_a), 64'(base));
                chk("first_wr_addr", 64'(use_b ? wr_addr_b : wr_addr_a), 64'd0);
            end
            if (use_b ? busy_b : busy_a) bc++;
            if (use_b ? done_b : done_a) got = 1;
        end
        chk("frame_done_seen", 64'(got), 64'd1);
        @(negedge clk);
        chk("busy_after_done", 64'(use_b ? busy_b : busy_a), 64'd0);
        chk("done_one_pulse", 64'(done_cnt), 64'd1);
        if (check_lat) chk("frame_latency", 64'(bc), 64'(npairs * (4 + lat) + 1));
        chk("write_count", 64'(wa_q.size()), 64'(npairs));
        for (int k = 0; k < npairs; k++) begin
            a   = base + 18'(2 * k);
            ph  = pix(a, seed, mem_mode);
            pl  = pix(a + 18'd1, seed, mem_mode);
            eop = {16'h0, ph[7:0], pl[7:0]};
            chk("operand", (k < op_q.size()) ? 64'(op_q[k]) : 'x, 64'(eop));
            chk("launch_mem_addr", (k < ma_q.size()) ? 64'(ma_q[k]) : 'x, 64'(a));
            chk("wr_addr", (k < wa_q.size()) ? 64'(wa_q[k]) : 'x, 64'(k));
            chk("wr_data", (k < wd_q.size()) ? 64'(wd_q[k]) : 'x, 64'(16'(eop[15:0] + 16'd1)));
        end
    endtask

    initial begin
        bit found;
        int wcount, dcount;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr", 64'(mem_addr_a), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr_a), 64'd0);
        chk("rst_operand", 64'(op_a), 64'd0);
        chk("rst_wr_data", 64'(wr_data_a), 64'd0);
        chk("rst_strobes", 64'({mstart_a, wr_en_a, busy_a, done_a, err_a}), 64'd0);
        chk("rst_b_mem_addr", 64'(mem_addr_b), 64'h3FFFE);
        chk("exp_const", 64'(exp_a), 64'd1927);
        chk("mod_const", 64'(mod_a), 64'd1349);
        @(posedge clk); #1; rst = 1'b0;

        // fixed memory, 5-cycle core, always ready
        mem_mode = 0; lat_fixed = 5; rdy_mode = 0;
        run_frame(0, 3, 18'd0, 1, 5);
        chk("pair0_data", (wd_q.size() > 0) ? 64'(wd_q[0]) : 'x, 64'h1123);

        // seven-cycle write stall on pair 1
        rdy_mode = 2; stall_cnt = 0; stall_seen = 0;
        run_frame(0, 3, 18'd0, 0, 5);
        chk("stall_cycles", 64'(stall_seen), 64'd7);
        rdy_mode = 0;

        // upper pixel bytes 0xAB must not reach the operand
        mem_mode = 2; seed = $urandom;
        run_frame(0, 3, 18'd0, 0, 5);

        // abort + start together in IDLE
        @(posedge clk); #1; start_a = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start_a = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_beats_start", 64'(busy_a), 64'd0);

        // abort during WAIT of pair 1
        mem_mode = 0;
        @(posedge clk); #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mstart_a && wr_addr_a == 18'd1) found = 1;
        end
        chk("pair1_launch_seen", 64'(found), 64'd1);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", 64'(busy_a), 64'd0);
        wcount = 0; dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_en_a) wcount++;
            if (done_a) dcount++;
        end
        chk("abort_no_write", 64'(wcount), 64'd0);
        chk("abort_no_done", 64'(dcount), 64'd0);
        run_frame(0, 3, 18'd0, 1, 5);

        // address wrap on the second instance
        mem_mode = 1; seed = $urandom;
        run_frame(1, 2, 18'h3FFFE, 1, 5);

        // randomized frames: random pixels, core latency, backpressure
        lat_fixed = 0; rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            seed = $urandom;
            run_frame(f == 1, (f == 1) ? 2 : 3, (f == 1) ? 18'h3FFFE : 18'd0, 0, 0);
        end
        rdy_mode = 0; lat_fixed = 5;

        // reset in the middle of a scan
        @(posedge clk); #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (12) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr_a), 64'd0);
        chk("midrst_wr_data", 64'(wr_data_a), 64'd0);
        chk("midrst_operand", 64'(op_a), 64'd0);
        repeat (10) @(posedge clk);

        // unresponsive core
        core_mute = 1;
        @(posedge clk); #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mstart_a) found = 1;
        end
        chk("mute_launch_seen", 64'(found), 64'd1);
`ifdef MODEX_TIMEOUT_EN
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("wd_wait_busy", 64'(busy_a), 64'd1);
            chk("wd_no_error_yet", 64'(err_a), 64'd0);
        end
        @(negedge clk);
        chk("wd_error_set", 64'(err_a), 64'd1);
        chk("wd_idle", 64'(busy_a), 64'd0);
        chk("wd_no_done", 64'(done_a), 64'd0);
        repeat (5) @(negedge clk);
        chk("wd_error_sticky", 64'(err_a), 64'd1);
`else
        repeat (40) @(negedge clk);
        chk("nowd_still_waiting", 64'(busy_a), 64'd1);
        chk("nowd_error_zero", 64'(err_a), 64'd0);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
`endif
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("error_cleared_by_rst", 64'(err_a), 64'd0);
        chk("idle_after_rst", 64'(busy_a), 64'd0);
        core_mute = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/modex_scan_controller.md
Name: modex_scan_controller

Overview:
Sequencer for the RSA pixel-decryption datapath. It walks the encrypted image memory two pixels at a time and packs each pair into one zero-extended operand. For each operand it issues a start/done handshake to the modular-exponentiation core and streams each ARQ-bit decrypted result to a downstream write port. It sits between the image ROM, the Mod_Exp core and the output buffer, and replaces free-running address drive with a controlled frame scan.

Parameters:
ARQ, 16, datapath width; operand is 2*ARQ, result is ARQ
ADDR, 18, memory address width
NUM_PAIRS, 4096, pixel pairs per frame; must be >=1
BASE_ADDR, 0, first pixel address of the frame
EXP_KEY, 1927, exponent driven to the core
MOD_KEY, 1349, modulus driven to the core
TIMEOUT, 65535, watchdog limit in cycles; used only with MODEX_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin frame scan; sampled only in IDLE
abort  in  1  cancel scan; return to IDLE next cycle
mem_addr  out  ADDR  address of the first pixel of the current pair
mem_data_hi  in  ARQ  pixel at mem_addr (combinational memory)
mem_data_lo  in  ARQ  pixel at mem_addr+1 (combinational memory)
modex_operand  out  2*ARQ  registered operand {zeros, hi[7:0], lo[7:0]}
modex_exp  out  ARQ  constant EXP_KEY
modex_mod  out  ARQ  constant MOD_KEY
modex_start  out  1  one-cycle launch pulse
modex_done  in  1  core result valid, level or pulse
modex_result  in  ARQ  core decrypted value
wr_en  out  1  output write valid
wr_ready  in  1  downstream accepts the write
wr_addr  out  ADDR  result index, 0..NUM_PAIRS-1
wr_data  out  ARQ  registered result
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at the end of the frame
error  out  1  sticky watchdog flag; stays 0 unless MODEX_TIMEOUT_EN is defined

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; mem_addr=BASE_ADDR; wr_addr=0.
  - modex_operand=0; wr_data=0.
  - modex_start, wr_en, busy, done, error all 0.
- States: IDLE, FETCH, LAUNCH, WAIT, WRITE, FIN.
- IDLE:
  - start=1 -> FETCH, with mem_addr=BASE_ADDR and wr_addr=0.
  - start outside IDLE is ignored.
- FETCH: register modex_operand = zero-extend({mem_data_hi[7:0], mem_data_lo[7:0]}) to 2*ARQ -> LAUNCH.
- LAUNCH: modex_start=1 for exactly this cycle -> WAIT.
- WAIT:
  - modex_done=1 -> register wr_data=modex_result -> WRITE.
  - modex_done seen in the LAUNCH cycle is ignored (stale).
- WRITE:
  - wr_en=1, with wr_addr and wr_data held stable until wr_ready=1.
  - On the handshake cycle, if wr_addr==NUM_PAIRS-1 -> FIN.
  - Otherwise mem_addr+=2 (wraps modulo 2^ADDR), wr_addr+=1 -> FETCH.
- FIN: done=1 for one cycle -> IDLE. mem_addr and wr_addr keep their final values.
- Minimum latency per pair is 4 cycles plus core latency plus write stall.
- Frame latency from start to done is NUM_PAIRS*(4+core+stall)+1.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; modex_start and wr_en drop the same edge.
  - done is not pulsed; no partial write is issued after abort.
  - abort and start together in IDLE: abort wins, stay IDLE.
- rst mid-scan: identical to the reset values above; the core must tolerate an abandoned operation.
- modex_exp and modex_mod are constant and unaffected by reset.

Optional Feature:
MODEX_TIMEOUT_EN
- Defined:
  - A TIMEOUT-wide counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without modex_done: error=1 (sticky until rst), state -> IDLE, done not pulsed.
- Not defined: no counter exists; WAIT waits indefinitely; error is tied to 0.

Test Plan:
1. NUM_PAIRS=3, BASE_ADDR=0, memory[0..5]=0x11,0x22,0x33,0x44,0x55,0x66; core model returns operand+1 after 5 cycles; wr_ready=1.
   -> operands 0x1122, 0x3344, 0x5566; writes (0,0x1123), (1,0x3345), (2,0x5567); done pulses once; busy falls with done.
2. Same setup, wr_ready low for 7 cycles on pair 1.
   -> wr_en, wr_addr=1 and wr_data=0x3345 held stable all 7 cycles; exactly one accepted write; mem_addr does not advance until the handshake.
3. Pixel upper bytes set to 0xAB.
   -> operand upper 2*ARQ-16 bits are 0; only the [7:0] bytes are used.
4. abort asserted during WAIT of pair 1.
   -> IDLE next cycle; no wr_en afterwards; done stays 0; a new start restarts at BASE_ADDR with wr_addr=0.
5. BASE_ADDR=2^18-2, NUM_PAIRS=2.
   -> mem_addr sequence 0x3FFFE, 0x00000 (wraps); two writes at wr_addr 0 and 1.
6. MODEX_TIMEOUT_EN, TIMEOUT=10, core never responds.
   -> error=1 exactly 10 WAIT cycles after entry; state IDLE; error persists until rst.
